// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the raw PS/2
// clock/data pins, deserialises 11-bit frames (start, 8 data LSB-first, odd parity,
// stop) and reports each byte with a one-cycle received or error strobe.
module ps2_frame_receiver #(
  parameter logic [15:0] over_time    = 16'd1000,
  parameter logic [3:0]  filter_depth = 4'd8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       device_clock,
  input  logic       device_data,
  output logic [7:0] register,
  output logic       recieved_flag,
  output logic       error_flag,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;

  state_t      state, state_nxt;
  logic        clk_sync_p0, clk_sync_p1;
  logic        dat_sync_p0, dat_sync_p1;
  logic        filt_clk;
  logic [3:0]  filt_cnt;
  logic        filt_toggle;
  logic        sample_evt;
  logic [3:0]  bit_count;
  logic [9:0]  shift;
  logic [15:0] timer;
  logic        timeout_hit;
  logic        frame_ok;
  logic        valid_q;
  logic        timeout_q;

  // Saturating increment so the frame timer never wraps.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_check(input logic [8:0] data_par, input logic stop);
    frame_check = (^data_par) & stop;
  endfunction

  // Filtered clock flips on the filter_depth-th consecutive differing sample.
  assign filt_toggle = (clk_sync_p1 != filt_clk) && (filt_cnt == filter_depth - 4'd1);
  // A falling edge of the filtered clock is the bit-sample event.
  assign sample_evt  = filt_toggle && filt_clk;
  // A sample event coinciding with the terminal count wins over the timeout.
  assign timeout_hit = (over_time != 16'd0) && (timer == over_time) && !sample_evt;
  // At the stop-bit event shift[9:1] holds data bits 0..7 and parity; the stop bit is live.
  assign frame_ok    = frame_check(shift[9:1], dat_sync_p1);

  // Two-flop synchronisers for both raw pins (idle-high line).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= device_clock;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= device_data;
      dat_sync_p1 <= dat_sync_p0;
    end
  end

  // Glitch filter: count consecutive synchronised samples that disagree with filt_clk.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= 4'd0;
    end else if (filt_toggle) begin
      filt_clk <= clk_sync_p1;
      filt_cnt <= 4'd0;
    end else if (clk_sync_p1 != filt_clk) begin
      filt_cnt <= filt_cnt + 4'd1;
    end else begin
      filt_cnt <= 4'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_evt && !dat_sync_p1) state_nxt = RECEIVE;
      RECEIVE: begin
        if (sample_evt && (bit_count == 4'd9)) state_nxt = CHECK;
        else if (timeout_hit)                  state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit capture, frame timer, output byte and strobe qualifiers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count <= 4'd0;
      shift     <= 10'd0;
      timer     <= 16'd0;
      register  <= 8'h00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == RECEIVE) && timeout_hit;
      case (state)
        IDLE: begin
          if (sample_evt && !dat_sync_p1) begin
            bit_count <= 4'd0;
            shift     <= 10'd0;
            timer     <= 16'd0;
          end
        end
        RECEIVE: begin
          if (sample_evt) begin
            shift     <= {dat_sync_p1, shift[9:1]};
            bit_count <= bit_count + 4'd1;
            timer     <= 16'd0;
            if (bit_count == 4'd9) begin
              valid_q <= frame_ok;
              if (frame_ok) register <= shift[8:1];
            end
          end else begin
            timer <= sat_inc(timer);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from state; busy covers only bit reception so it is low in any strobe cycle.
  always_comb begin
    recieved_flag = (state == CHECK) && valid_q;
    error_flag    = ((state == CHECK) && !valid_q) || timeout_q;
    busy          = (state == RECEIVE);
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed frame scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_ps2_frame_receiver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       device_clock = 1'b1;
  logic       device_data = 1'b1;
  logic [7:0] register;
  logic       recieved_flag;
  logic       error_flag;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int viol = 0;
  int last_fall_cyc = 0;
  logic [7:0] exp_reg = 8'h00;

  ps2_frame_receiver #(.over_time(16'd1000), .filter_depth(4'd8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .device_clock(device_clock),
    .device_data(device_data),
    .register(register),
    .recieved_flag(recieved_flag),
    .error_flag(error_flag),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (recieved_flag) rx_cnt++;
    if (error_flag) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (recieved_flag && error_flag) viol++;
    if ((recieved_flag || error_flag) && busy) viol++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive the first nbits bits of a frame; glitch_bit >= 0 adds a 3-cycle low
  // pulse on the clock line during that bit's high phase.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input int glitch_bit, input int hp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      device_data = bits[i];
      wait_cyc(hp / 2);
      device_clock = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(hp);
      device_clock = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(10);
        device_clock = 1'b0;
        wait_cyc(3);
        device_clock = 1'b1;
        wait_cyc(hp / 2 - 13);
      end else begin
        wait_cyc(hp / 2);
      end
    end
    device_data = 1'b1;
  endtask

  // Send one frame and compare strobe counts and the output byte to expectations.
  task automatic frame_and_check(input string name, input logic [7:0] d, input logic par,
                                 input logic stp, input int glitch_bit, input int hp);
    int r0, e0;
    logic exp_ok;
    exp_ok = ((($countones(d) + int'(par)) % 2) == 1) && stp;
    if (exp_ok) exp_reg = d;
    r0 = rx_cnt;
    e0 = err_cnt;
    send_frame(d, par, stp, 11, glitch_bit, hp);
    wait_cyc(3 * hp);
    checks++;
    if ((rx_cnt - r0) !== (exp_ok ? 1 : 0)) begin
      errors++;
      $display("FAIL %s rx_pulses got %0d want %0d", name, rx_cnt - r0, exp_ok ? 1 : 0);
    end
    checks++;
    if ((err_cnt - e0) !== (exp_ok ? 0 : 1)) begin
      errors++;
      $display("FAIL %s err_pulses got %0d want %0d", name, err_cnt - e0, exp_ok ? 0 : 1);
    end
    checks++;
    if (register !== exp_reg) begin
      errors++;
      $display("FAIL %s register got %h want %h", name, register, exp_reg);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (register !== 8'h00) begin
      errors++;
      $display("FAIL %s register got %h want 00", name, register);
    end
    checks++;
    if (recieved_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s recieved_flag got %b want 0", name, recieved_flag);
    end
    checks++;
    if (error_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s error_flag got %b want 0", name, error_flag);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(5);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_good_frame();
    frame_and_check("good_1C", 8'h1C, 1'b0, 1'b1, -1, 100);
  endtask

  task automatic test_parity_error();
    frame_and_check("parity_F0", 8'hF0, 1'b0, 1'b1, -1, 100);
  endtask

  task automatic test_stop_error();
    frame_and_check("stop_5A", 8'h5A, 1'b1, 1'b0, -1, 100);
    frame_and_check("good_5A", 8'h5A, 1'b1, 1'b1, -1, 100);
  endtask

  task automatic test_timeout();
    int e0, r0, n, dt;
    e0 = err_cnt;
    r0 = rx_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 6, -1, 100);
    n = 0;
    while (err_cnt == e0 && n < 1400) begin
      wait_cyc(1);
      n++;
    end
    dt = err_cyc - last_fall_cyc;
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL timeout_err_pulses got %0d want 1", err_cnt - e0);
    end
    checks++;
    if (dt < 1000 || dt > 1030) begin
      errors++;
      $display("FAIL timeout_delay got %0d want 1000..1030 cycles after last raw edge", dt);
    end
    wait_cyc(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy got %b want 0", busy);
    end
    checks++;
    if (rx_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL timeout_rx_pulses got %0d want 0", rx_cnt - r0);
    end
    wait_cyc(100);
    frame_and_check("after_timeout_29", 8'h29, 1'b0, 1'b1, -1, 100);
  endtask

  task automatic test_glitch();
    int r0, e0;
    r0 = rx_cnt;
    e0 = err_cnt;
    device_data = 1'b1;
    wait_cyc(50);
    device_clock = 1'b0;
    wait_cyc(100);
    device_clock = 1'b1;
    wait_cyc(300);
    checks++;
    if ((rx_cnt - r0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL stray_edge strobes got rx=%0d err=%0d want 0 0", rx_cnt - r0, err_cnt - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_edge_busy got %b want 0", busy);
    end
    frame_and_check("glitch_76", 8'h76, 1'b0, 1'b1, 4, 100);
  endtask

  task automatic test_reset_midframe();
    int r0, e0;
    r0 = rx_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 5, -1, 100);
    device_data = 1'b1;
    reset_n = 1'b0;
    wait_cyc(10);
    exp_reg = 8'h00;
    check_reset_outputs("reset_mid");
    reset_n = 1'b1;
    wait_cyc(300);
    checks++;
    if ((rx_cnt - r0) !== 0 || (err_cnt - e0) !== 0) begin
      errors++;
      $display("FAIL reset_mid strobes got rx=%0d err=%0d want 0 0", rx_cnt - r0, err_cnt - e0);
    end
    frame_and_check("after_reset_12", 8'h12, 1'b1, 1'b1, -1, 100);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic par, stp;
    int hp;
    for (int k = 0; k < 12; k++) begin
      d   = 8'($urandom);
      par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 4) != 0);
      hp  = int'($urandom_range(40, 100));
      frame_and_check($sformatf("rand%0d", k), d, par, stp, -1, hp);
    end
  endtask

  task automatic test_back_to_back();
    frame_and_check("b2b_A", 8'h3C, 1'b1, 1'b1, -1, 60);
    frame_and_check("b2b_B", 8'hC3, 1'b1, 1'b1, -1, 60);
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_invariants got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
